// File: rtl/can_pkg.sv
// Shared CAN receive-path definitions: destuffer FSM states, bus levels, default run length.
package can_pkg;
    typedef enum logic [1:0] {OFF, RUN, STUFF, ERROR} destuff_state_e;

    localparam logic DOMINANT      = 1'b0;
    localparam logic RECESSIVE     = 1'b1;
    localparam int   STUFF_LEN_DEF = 5;
endpackage

// File: rtl/bit_destuffer.sv
// CAN receive bit destuffer: tracks identical-bit runs at each sample point, flags the
// upcoming stuff bit, drops it from the data stream and reports stuff-rule violations.
module bit_destuffer
    import can_pkg::*;
#(
    parameter int STUFF_LEN = STUFF_LEN_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic sp,
    input  logic rx,
    input  logic enable,
    output logic isStuff,
    output logic bitOut,
    output logic bitValid,
    output logic stuffError
);
    localparam int             CW      = $clog2(STUFF_LEN + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STUFF_LEN);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    destuff_state_e state_q;
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  count_d;
    logic           last_q;
    logic           is_stuff_q;
    logic           bit_out_q;
    logic           bit_valid_q;
    logic           stuff_err_q;

    // Run length after accepting rx; saturating so it can never wrap.
    always_comb begin
        count_d = CNT_ONE;
        if (rx == last_q) begin
            count_d = (count_q == CNT_MAX) ? CNT_MAX : count_q + CNT_ONE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= OFF;
            count_q     <= '0;
            last_q      <= RECESSIVE;
            is_stuff_q  <= 1'b0;
            bit_out_q   <= RECESSIVE;
            bit_valid_q <= 1'b0;
            stuff_err_q <= 1'b0;
        end else begin
            bit_valid_q <= 1'b0;
            if (sp) begin
                case (state_q)
                    OFF: begin
                        bit_out_q   <= rx;
                        bit_valid_q <= 1'b1;
                        if (enable) begin
                            // SOF is the first bit of the first run
                            last_q  <= rx;
                            count_q <= CNT_ONE;
                            state_q <= RUN;
                        end else begin
                            count_q <= '0;
                        end
                    end
                    RUN: begin
                        bit_out_q   <= rx;
                        bit_valid_q <= 1'b1;
                        if (enable) begin
                            last_q  <= rx;
                            count_q <= count_d;
                            if (count_d == CNT_MAX) begin
                                is_stuff_q <= 1'b1;
                                state_q    <= STUFF;
                            end
                        end else begin
                            count_q <= '0;
                            state_q <= OFF;
                        end
                    end
                    STUFF: begin
                        // enable ignored: a stuff bit trailing the CRC is still consumed
                        is_stuff_q <= 1'b0;
                        if (rx != last_q) begin
                            last_q  <= rx;
                            count_q <= CNT_ONE;
                            state_q <= enable ? RUN : OFF;
                        end else begin
                            stuff_err_q <= 1'b1;
                            state_q     <= ERROR;
                        end
                    end
                    ERROR: begin
                        if (!enable) begin
                            stuff_err_q <= 1'b0;
                            state_q     <= OFF;
                        end
                    end
                    default: state_q <= OFF;
                endcase
            end
        end
    end

    assign isStuff    = is_stuff_q;
    assign bitOut     = bit_out_q;
    assign bitValid   = bit_valid_q;
    assign stuffError = stuff_err_q;
endmodule

// File: tb/tb_bit_destuffer.sv
// Directed bench for bit_destuffer, with a small frame-size counter model driven by isStuff.
module tb_bit_destuffer;
    import can_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic sp = 1'b0;
    logic rx = RECESSIVE;
    logic enable = 1'b0;
    logic isStuff, bitOut, bitValid, stuffError;

    int nchk = 0;
    int nerr = 0;
    int sz = 0;
    logic sz_clr = 1'b0;
    int nvalid;
    int nmatch;
    int nstuff;

    always #5 clock = ~clock;

    bit_destuffer #(.STUFF_LEN(5)) dut (
        .clock(clock), .reset(reset), .sp(sp), .rx(rx), .enable(enable),
        .isStuff(isStuff), .bitOut(bitOut), .bitValid(bitValid), .stuffError(stuffError)
    );

    // Downstream frame-size counter: counts sample points that are not stuff bits.
    always @(posedge clock) begin
        if (sz_clr) sz <= 0;
        else if (sp && !isStuff) sz <= sz + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One sample-point strobe; returns one cycle after sp with registered outputs updated.
    task automatic strobe(input logic b, input logic en);
        @(negedge clock);
        sp = 1'b1; rx = b; enable = en;
        @(negedge clock);
        sp = 1'b0;
        enable = ~en;  // toggling between strobes must not matter
    endtask

    initial begin
        #12;
        chk("reset_isStuff", {31'b0, isStuff}, 32'd0);
        chk("reset_bitOut", {31'b0, bitOut}, 32'd1);
        chk("reset_bitValid", {31'b0, bitValid}, 32'd0);
        chk("reset_stuffError", {31'b0, stuffError}, 32'd0);
        @(negedge clock); reset = 1'b1;
        @(negedge clock); sz_clr = 1'b1;
        @(negedge clock); sz_clr = 1'b0;

        // Five dominant bits then stuff bit 1
        for (int i = 0; i < 5; i++) begin
            strobe(DOMINANT, 1'b1);
            chk("t1_valid", {31'b0, bitValid}, 32'd1);
            chk("t1_isStuff", {31'b0, isStuff}, (i == 4) ? 32'd1 : 32'd0);
        end
        strobe(RECESSIVE, 1'b1);
        chk("t1_stuff_valid", {31'b0, bitValid}, 32'd0);
        chk("t1_stuff_clr", {31'b0, isStuff}, 32'd0);
        chk("t1_bitOut_held", {31'b0, bitOut}, 32'd0);
        chk("t1_size", sz, 32'd5);

        // Six dominant bits -> stuff error
        strobe(RECESSIVE, 1'b0);
        for (int i = 0; i < 6; i++) strobe(DOMINANT, 1'b1);
        chk("t2_err", {31'b0, stuffError}, 32'd1);
        chk("t2_err_valid", {31'b0, bitValid}, 32'd0);
        strobe(DOMINANT, 1'b1);
        chk("t2_hold_valid0", {31'b0, bitValid}, 32'd0);
        strobe(RECESSIVE, 1'b1);
        chk("t2_hold_valid1", {31'b0, bitValid}, 32'd0);
        chk("t2_hold_err", {31'b0, stuffError}, 32'd1);
        strobe(RECESSIVE, 1'b0);
        chk("t2_clr_err", {31'b0, stuffError}, 32'd0);
        chk("t2_clr_valid", {31'b0, bitValid}, 32'd0);
        strobe(DOMINANT, 1'b0);
        chk("t2_off_pass_valid", {31'b0, bitValid}, 32'd1);
        chk("t2_off_pass_bit", {31'b0, bitOut}, 32'd0);

        // Alternating bits never stuff
        nvalid = 0; nmatch = 0; nstuff = 0;
        for (int i = 0; i < 20; i++) begin
            strobe(i[0], 1'b1);
            if (bitValid) nvalid++;
            if (bitValid && bitOut == i[0]) nmatch++;
            if (isStuff) nstuff++;
        end
        chk("t3_valid_cnt", nvalid, 32'd20);
        chk("t3_bit_match", nmatch, 32'd20);
        chk("t3_isStuff", nstuff, 32'd0);

        // Trailing CRC run of ones, enable dropped at the stuff bit
        strobe(RECESSIVE, 1'b0);
        for (int i = 0; i < 5; i++) strobe(RECESSIVE, 1'b1);
        chk("t4_isStuff", {31'b0, isStuff}, 32'd1);
        strobe(DOMINANT, 1'b0);
        chk("t4_stuff_valid", {31'b0, bitValid}, 32'd0);
        chk("t4_stuff_clr", {31'b0, isStuff}, 32'd0);
        chk("t4_stuff_err", {31'b0, stuffError}, 32'd0);
        chk("t4_bitOut_held", {31'b0, bitOut}, 32'd1);
        strobe(DOMINANT, 1'b0);
        chk("t4_pass_valid", {31'b0, bitValid}, 32'd1);
        chk("t4_pass_bit", {31'b0, bitOut}, 32'd0);
        strobe(RECESSIVE, 1'b0);
        chk("t4_pass_rec", {31'b0, bitOut}, 32'd1);
        chk("t4_pass_rec_stuff", {31'b0, isStuff}, 32'd0);

        // Asynchronous reset mid-run
        for (int i = 0; i < 4; i++) strobe(DOMINANT, 1'b1);
        chk("t5_pre_bit", {31'b0, bitOut}, 32'd0);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("t5_rst_bitOut", {31'b0, bitOut}, 32'd1);
        chk("t5_rst_isStuff", {31'b0, isStuff}, 32'd0);
        chk("t5_rst_valid", {31'b0, bitValid}, 32'd0);
        chk("t5_rst_err", {31'b0, stuffError}, 32'd0);
        @(negedge clock); reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            strobe(DOMINANT, 1'b1);
            chk("t5_restart", {31'b0, isStuff}, 32'd0);
        end
        strobe(DOMINANT, 1'b1);
        chk("t5_fourth", {31'b0, isStuff}, 32'd0);
        strobe(DOMINANT, 1'b1);
        chk("t5_fifth", {31'b0, isStuff}, 32'd1);

        // Stuff-bit chaining: the stuff bit opens a new run
        strobe(RECESSIVE, 1'b0);
        for (int i = 0; i < 5; i++) strobe(DOMINANT, 1'b1);
        chk("t6_first_stuff", {31'b0, isStuff}, 32'd1);
        strobe(RECESSIVE, 1'b1);
        chk("t6_stuff_valid", {31'b0, bitValid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            strobe(RECESSIVE, 1'b1);
            chk("t6_chain", {31'b0, isStuff}, (i == 3) ? 32'd1 : 32'd0);
            chk("t6_chain_valid", {31'b0, bitValid}, 32'd1);
        end
        strobe(DOMINANT, 1'b1);
        chk("t6_second_consumed", {31'b0, bitValid}, 32'd0);
        chk("t6_no_err", {31'b0, stuffError}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
